// File: rtl/rs_array.sv
// Reservation station array: in-order allocation into the lowest free slot,
// CDB wakeup of pending operands, and single-issue dispatch of the lowest
// ready entry into registered ALU outputs.

// One reservation-station slot. Allocation and dispatch selects arrive
// already qualified by the array, and the operands arrive with any issue-time
// CDB bypass already applied.
module rs_entry #(
    parameter int ROB_BIT = 3,
    parameter int OP_W    = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush,
    input  logic               alloc,
    input  logic               disp,
    input  logic [OP_W-1:0]    new_op,
    input  logic [31:0]        new_vj,
    input  logic [31:0]        new_vk,
    input  logic               new_qj_valid,
    input  logic               new_qk_valid,
    input  logic [ROB_BIT-1:0] new_qj,
    input  logic [ROB_BIT-1:0] new_qk,
    input  logic [ROB_BIT-1:0] new_dest,
    input  logic               cdb_valid,
    input  logic [ROB_BIT-1:0] cdb_tag,
    input  logic [31:0]        cdb_value,
    output logic               busy,
    output logic               prepared,
    output logic [OP_W-1:0]    op,
    output logic [31:0]        vj,
    output logic [31:0]        vk,
    output logic [ROB_BIT-1:0] dest
);
    logic               qj_valid, qk_valid;
    logic [ROB_BIT-1:0] qj, qk;
    logic               wake_j, wake_k;

    // Ready to dispatch only once both operands are in hand.
    assign prepared = busy && !qj_valid && !qk_valid;
    assign wake_j   = busy && qj_valid && cdb_valid && (qj == cdb_tag);
    assign wake_k   = busy && qk_valid && cdb_valid && (qk == cdb_tag);

    // Slot state: flush beats everything; alloc only ever targets a free slot,
    // so it never collides with dispatch or wakeup of the same slot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy     <= 1'b0;
            op       <= '0;
            vj       <= '0;
            vk       <= '0;
            qj_valid <= 1'b0;
            qk_valid <= 1'b0;
            qj       <= '0;
            qk       <= '0;
            dest     <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (alloc) begin
            busy     <= 1'b1;
            op       <= new_op;
            vj       <= new_vj;
            vk       <= new_vk;
            qj_valid <= new_qj_valid;
            qk_valid <= new_qk_valid;
            qj       <= new_qj;
            qk       <= new_qk;
            dest     <= new_dest;
        end else if (rdy_in) begin
            if (disp)
                busy <= 1'b0;
            if (wake_j) begin
                vj       <= cdb_value;
                qj_valid <= 1'b0;
            end
            if (wake_k) begin
                vk       <= cdb_value;
                qk_valid <= 1'b0;
            end
        end
    end
endmodule

module rs_array #(
    parameter int RS_SIZE = 16,
    parameter int RS_BIT  = 4,
    parameter int ROB_BIT = 3,
    parameter int OP_W    = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush,
    input  logic               issue_valid,
    input  logic [OP_W-1:0]    issue_op,
    input  logic [31:0]        issue_vj,
    input  logic [31:0]        issue_vk,
    input  logic               issue_qj_valid,
    input  logic               issue_qk_valid,
    input  logic [ROB_BIT-1:0] issue_qj,
    input  logic [ROB_BIT-1:0] issue_qk,
    input  logic [ROB_BIT-1:0] issue_dest,
    input  logic               cdb_valid,
    input  logic [ROB_BIT-1:0] cdb_tag,
    input  logic [31:0]        cdb_value,
    output logic               full,
    output logic               exe_valid,
    output logic [OP_W-1:0]    exe_op,
    output logic [31:0]        exe_v1,
    output logic [31:0]        exe_v2,
    output logic [ROB_BIT-1:0] exe_dest
);
    logic [RS_SIZE-1:0]              busy, prepared, alloc_sel, disp_sel;
    logic [RS_SIZE-1:0][OP_W-1:0]    ent_op;
    logic [RS_SIZE-1:0][31:0]        ent_vj, ent_vk;
    logic [RS_SIZE-1:0][ROB_BIT-1:0] ent_dest;

    logic [RS_BIT-1:0] alloc_idx, disp_idx;
    logic              alloc_en, disp_en;
    logic              byp_j, byp_k;
    logic [31:0]       new_vj, new_vk;

    assign full     = &busy;
    assign alloc_en = rdy_in && issue_valid && !full && !flush;
    assign disp_en  = rdy_in && !flush && (|prepared);

    // An operand produced on the CDB in the issue cycle is captured directly,
    // since the entry does not exist yet to see the broadcast.
    assign byp_j  = issue_qj_valid && cdb_valid && (issue_qj == cdb_tag);
    assign byp_k  = issue_qk_valid && cdb_valid && (issue_qk == cdb_tag);
    assign new_vj = byp_j ? cdb_value : issue_vj;
    assign new_vk = byp_k ? cdb_value : issue_vk;

    // Lowest-index free slot (scan downward so the lowest hit wins).
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy[i])
                alloc_idx = RS_BIT'(i);
    end

    // Lowest-index prepared slot.
    always_comb begin
        disp_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (prepared[i])
                disp_idx = RS_BIT'(i);
    end

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        assign alloc_sel[g] = alloc_en && (alloc_idx == RS_BIT'(g));
        assign disp_sel[g]  = disp_en && (disp_idx == RS_BIT'(g));

        rs_entry #(.ROB_BIT(ROB_BIT), .OP_W(OP_W)) u_ent (
            .clk_in       (clk_in),
            .rst_in       (rst_in),
            .rdy_in       (rdy_in),
            .flush        (flush),
            .alloc        (alloc_sel[g]),
            .disp         (disp_sel[g]),
            .new_op       (issue_op),
            .new_vj       (new_vj),
            .new_vk       (new_vk),
            .new_qj_valid (issue_qj_valid && !byp_j),
            .new_qk_valid (issue_qk_valid && !byp_k),
            .new_qj       (issue_qj),
            .new_qk       (issue_qk),
            .new_dest     (issue_dest),
            .cdb_valid    (cdb_valid),
            .cdb_tag      (cdb_tag),
            .cdb_value    (cdb_value),
            .busy         (busy[g]),
            .prepared     (prepared[g]),
            .op           (ent_op[g]),
            .vj           (ent_vj[g]),
            .vk           (ent_vk[g]),
            .dest         (ent_dest[g])
        );
    end

    // Dispatch register: valid pulses for one cycle, payload holds otherwise.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            exe_valid <= 1'b0;
            exe_op    <= '0;
            exe_v1    <= '0;
            exe_v2    <= '0;
            exe_dest  <= '0;
        end else begin
            exe_valid <= disp_en;
            if (disp_en) begin
                exe_op   <= ent_op[disp_idx];
                exe_v1   <= ent_vj[disp_idx];
                exe_v2   <= ent_vk[disp_idx];
                exe_dest <= ent_dest[disp_idx];
            end
        end
    end
endmodule
